round_robin_grant: RTL

Registered round-robin arbiter producing the one-hot select that drives the team's one-hot word multiplexer, directly upstream of it. N requesters compete for a shared datapath. The block grants exactly one of them with a one-hot GRANT vector and holds that grant until the owner signals RELEASE. Fairness comes from a rotating priority pointer.

---
 rtl/round_robin_grant_pkg.sv | 8 +
 rtl/round_robin_grant_priority_one_hot.sv | 37 +++
 rtl/round_robin_grant.sv | 94 +++++++++
 3 files changed

// File: rtl/round_robin_grant_pkg.sv
// Shared helpers for the round-robin grant arbiter and its priority picker.
package round_robin_grant_pkg;

    function automatic int wrapNext(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_grant_priority_one_hot.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module priority_one_hot
    import round_robin_grant_pkg::*;
#(
    parameter int REQ_COUNT   = 4,
    parameter int INDEX_WIDTH = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0]   req_i,
    input  logic [INDEX_WIDTH-1:0] ptr_i,
    output logic [REQ_COUNT-1:0]   grant_o,
    output logic [INDEX_WIDTH-1:0] index_o
);

    logic [REQ_COUNT-1:0] mask;
    logic [REQ_COUNT-1:0] masked;
    logic [REQ_COUNT-1:0] source;
    logic [REQ_COUNT-1:0] pick;

    // Requests below the pointer only win when nothing at or above it is pending.
    always_comb begin
        mask = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            mask[i] = (i >= int'(ptr_i));
        end
        masked  = req_i & mask;
        source  = (|masked) ? masked : req_i;
        pick    = source & (~source + REQ_COUNT'(1));
        index_o = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (pick[i]) begin
                index_o = INDEX_WIDTH'(i);
            end
        end
        grant_o = pick;
    end

endmodule

// File: rtl/round_robin_grant.sv
// Registered round-robin arbiter; the grant is held until the owner pulses release.
module round_robin_grant
    import round_robin_grant_pkg::*;
#(
    parameter int REQ_COUNT   = 4,
    parameter int INDEX_WIDTH = $clog2(REQ_COUNT)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [REQ_COUNT-1:0]   requests_i,
    input  logic                   release_i,
    output logic [REQ_COUNT-1:0]   grant_o,
    output logic                   grantValid_o,
    output logic [INDEX_WIDTH-1:0] grantIndex_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [REQ_COUNT-1:0]   grant_q, grant_d;
    logic                   grantValid_q, grantValid_d;
    logic [INDEX_WIDTH-1:0] grantIdx_q, grantIdx_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] searchPtr;
    logic [REQ_COUNT-1:0]   arbGrant;
    logic [INDEX_WIDTH-1:0] arbIdx;
    logic                   anyReq;
    logic                   handOff;

    assign anyReq  = |requests_i;
    assign handOff = (state_q == OWNED) && release_i;

    // On hand-off the outgoing owner drops to lowest priority before the same-cycle search.
    assign searchPtr = handOff ? INDEX_WIDTH'(wrapNext(int'(grantIdx_q), REQ_COUNT)) : ptr_q;

    priority_one_hot #(
        .REQ_COUNT   (REQ_COUNT),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .req_i   (requests_i),
        .ptr_i   (searchPtr),
        .grant_o (arbGrant),
        .index_o (arbIdx)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
            grantIdx_q   <= '0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grantValid_q <= grantValid_d;
            grantIdx_q   <= grantIdx_d;
            ptr_q        <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (anyReq) state_d = OWNED;
            OWNED:   if (release_i && !anyReq) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no requests the picker yields zero grant and index, which doubles as the idle value.
    always_comb begin
        grant_d      = grant_q;
        grantValid_d = grantValid_q;
        grantIdx_d   = grantIdx_q;
        ptr_d        = ptr_q;
        if ((state_q == IDLE) || handOff) begin
            grant_d      = arbGrant;
            grantValid_d = anyReq;
            grantIdx_d   = arbIdx;
        end
        if (handOff) begin
            ptr_d = searchPtr;
        end
    end

    assign grant_o      = grant_q;
    assign grantValid_o = grantValid_q;
    assign grantIndex_o = grantIdx_q;

endmodule
